// File: rtl/mem_responder.sv
// Fixed-latency 128-bit line memory responder with a valid/ready request and response handshake.
// Optional out-of-range checking is enabled with `define MEM_RESP_RANGE_CHECK_EN.
module mem_responder #(
   parameter int NUM_LINES = 256,
   parameter int LATENCY   = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic         req_we,
   input  logic [31:0]  req_addr,
   input  logic [127:0] req_wdata,
   output logic         resp_valid,
   input  logic         resp_ready,
   output logic [127:0] resp_rdata,
   output logic         resp_err
);

   // state | meaning
   // IDLE  | ready for a request; response outputs are 0
   // WAIT  | request latched; counting down the remaining latency
   // RESP  | access performed; response held until resp_ready
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int AW = $clog2(NUM_LINES);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   logic [127:0] mem [NUM_LINES];

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           we_q, we_d;
   logic [AW-1:0]  idx_q, idx_d;
   logic [127:0]   wdata_q, wdata_d;
   logic           oor_q, oor_d;
   logic [127:0]   rdata_q, rdata_d;
   logic           err_q, err_d;

   logic           accept;
   logic           enter_resp;
   logic [AW-1:0]  req_idx;
   logic           req_oor;
   logic           acc_we;
   logic [AW-1:0]  acc_idx;
   logic [127:0]   acc_wdata;
   logic           acc_oor;

   assign req_idx = req_addr[4 +: AW];

`ifdef MEM_RESP_RANGE_CHECK_EN
   localparam logic [31:0] HI_MASK = ~((32'd1 << (4 + AW)) - 32'd1);
   logic unused_addr;
   assign unused_addr = ^req_addr[3:0];
   assign req_oor     = |(req_addr & HI_MASK);
`else
   logic unused_addr;
   assign unused_addr = ^{req_addr[3:0], req_addr[31:4+AW]};
   assign req_oor     = 1'b0;
`endif

   assign accept = rst && req_valid && (state_q == IDLE);

   // With LATENCY = 1 the access happens on the acceptance edge itself,
   // so the live request inputs are used instead of the latched copies.
   assign acc_we    = (state_q == IDLE) ? req_we    : we_q;
   assign acc_idx   = (state_q == IDLE) ? req_idx   : idx_q;
   assign acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
   assign acc_oor   = (state_q == IDLE) ? req_oor   : oor_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      idx_d      = idx_q;
      wdata_d    = wdata_q;
      oor_d      = oor_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      enter_resp = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               we_d    = req_we;
               idx_d   = req_idx;
               wdata_d = req_wdata;
               oor_d   = req_oor;
               if (LATENCY == 1) begin
                  state_d    = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CW'(LATENCY - 1);
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d    = RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_d = IDLE;
               rdata_d = '0;
               err_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      if (enter_resp) begin
         rdata_d = (acc_we || acc_oor) ? 128'd0 : mem[acc_idx];
         err_d   = acc_oor;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         oor_q   <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         oor_q   <= oor_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Storage is deliberately not reset; contents survive rst.
   always_ff @(posedge clk) begin
      if (enter_resp && acc_we && !acc_oor) begin
         mem[acc_idx] <= acc_wdata;
      end
   end

   assign req_ready  = rst && (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: reset, latency, write/read, backpressure,
// mid-operation reset and address range handling.
module tb_mem_responder;

   logic         clk;
   logic         rst;
   logic         req_valid;
   logic         req_ready;
   logic         req_we;
   logic [31:0]  req_addr;
   logic [127:0] req_wdata;
   logic         resp_valid;
   logic         resp_ready;
   logic [127:0] resp_rdata;
   logic         resp_err;

   int tests = 0;
   int fails = 0;

   localparam logic [127:0] L0 = 128'h00100093_00200113_002081b3_00200113;
   localparam logic [127:0] L1 = 128'h00300293_00300313_00310333_00300313;
   localparam logic [127:0] L2 = 128'hdeadbeef_cafef00d_01234567_89abcdef;
   localparam logic [127:0] L3 = 128'h11111111_22222222_33333333_44444444;

   mem_responder #(.NUM_LINES(256), .LATENCY(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one request, scramble the request inputs after acceptance, and
   // measure cycles from the acceptance edge to resp_valid (99 = timeout).
   task automatic do_req(input logic we, input logic [31:0] addr, input logic [127:0] wd,
                         output int lat, output logic [127:0] rd, output logic er);
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_we    = ~we;
      req_addr  = 32'hFFFF_FFF0;
      req_wdata = '1;
      lat = 99;
      rd  = 'x;
      er  = 1'bx;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         #1;
         if (resp_valid) begin
            lat = c;
            break;
         end
      end
      rd = resp_rdata;
      er = resp_err;
      if (resp_ready && lat != 99) begin
         @(posedge clk);
         #1;
      end
   endtask

   int           lat;
   logic [127:0] rd;
   logic         er;
   logic         seen;

   initial begin
      rst        = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      resp_ready = 1'b1;
      dut.mem[0] = L0;
      dut.mem[1] = '0;
      dut.mem[2] = L2;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready_low", {127'd0, req_ready}, 128'd0);
      chk("rst_resp_valid_low", {127'd0, resp_valid}, 128'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_req_ready", {127'd0, req_ready}, 128'd1);
      chk("post_rst_outputs", {resp_rdata[126:0], resp_valid, resp_err} == 129'd0 ? 128'd0 : 128'd1, 128'd0);

      do_req(1'b0, 32'h0000_0000, '0, lat, rd, er);
      chk("rd0_latency", 128'(lat), 128'd4);
      chk("rd0_rdata", rd, L0);
      chk("rd0_err", {127'd0, er}, 128'd0);
      chk("rd0_back_idle", {126'd0, req_ready, resp_valid}, 128'b10);

      do_req(1'b1, 32'h0000_0010, L1, lat, rd, er);
      chk("wr1_latency", 128'(lat), 128'd4);
      chk("wr1_rdata_zero", rd, 128'd0);
      chk("wr1_mem", dut.mem[1], L1);
      do_req(1'b0, 32'h0000_0014, '0, lat, rd, er);
      chk("rd14_rdata", rd, L1);

      resp_ready = 1'b0;
      do_req(1'b0, 32'h0000_0010, '0, lat, rd, er);
      chk("bp_latency", 128'(lat), 128'd4);
      chk("bp_rdata", rd, L1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("bp_hold_rdata", resp_rdata, L1);
         chk("bp_hold_flags", {125'd0, resp_valid, resp_err, req_ready}, 128'b100);
      end
      @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release", {126'd0, resp_valid, req_ready}, 128'b01);

      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 32'h0000_0020;
      req_wdata = L3;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         if (resp_valid) seen = 1'b1;
      end
      chk("midrst_no_resp", {127'd0, seen}, 128'd0);
      chk("midrst_mem2", dut.mem[2], L2);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_ready", {127'd0, req_ready}, 128'd1);
      do_req(1'b0, 32'h0000_0020, '0, lat, rd, er);
      chk("midrst_readback", rd, L2);

      do_req(1'b0, 32'h0000_1000, '0, lat, rd, er);
      chk("range_latency", 128'(lat), 128'd4);
`ifdef MEM_RESP_RANGE_CHECK_EN
      chk("range_rdata", rd, 128'd0);
      chk("range_err", {127'd0, er}, 128'd1);
`else
      chk("range_rdata", rd, L0);
      chk("range_err", {127'd0, er}, 128'd0);
`endif
      chk("range_idle", {127'd0, resp_err}, 128'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter NUM_LINES, default 256, meaning the number of 128-bit memory lines (power of two, at least 2).
REQ-002 SHALL have parameter LATENCY, default 4, meaning the cycles from request acceptance to resp_valid (at least 1).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning the reset: asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  meaning the initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  meaning the responder can accept a request.
REQ-007 SHALL have port req_we  input  1  meaning 1 = line write, 0 = line read.
REQ-008 SHALL have port req_addr  input  32  meaning the byte address; bits [3:0] are ignored.
REQ-009 SHALL have port req_wdata  input  128  meaning the write line; word 0 is in bits [127:96].
REQ-010 SHALL have port resp_valid  output  1  meaning a response is pending.
REQ-011 SHALL have port resp_ready  input  1  meaning the initiator accepts the response.
REQ-012 SHALL have port resp_rdata  output  128  meaning the read line (0 for writes).
REQ-013 SHALL have port resp_err  output  1  meaning an out-of-range address (see Configuration).
REQ-014 SHALL hold its storage in an internal array named mem of NUM_LINES x 128 bits, so benches can access it directly by hierarchical reference.

Function
REQ-015 SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-016 SHALL drive req_ready = 1 only in IDLE; acceptance occurs on a rising edge with req_valid && req_ready.
REQ-017 SHALL latch req_we, the line index and req_wdata on acceptance; later changes on the request inputs have no effect.
REQ-018 SHALL compute the line index as req_addr[4 +: log2(NUM_LINES)].
REQ-019 SHALL, on acceptance, load a counter with LATENCY-1 and go to WAIT; if LATENCY = 1, it goes directly to RESP.
REQ-020 SHALL decrement the counter once per cycle in WAIT and move to RESP on the edge where the counter is 0.
REQ-021 SHALL assert resp_valid exactly LATENCY cycles after the acceptance edge.
REQ-022 SHALL perform a read on the entry edge to RESP: resp_rdata = mem[index] sampled at that edge, including any write completed on that same edge.
REQ-023 SHALL perform a write on the entry edge to RESP: mem[index] is updated and resp_rdata = 0.
REQ-024 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until resp_ready = 1.
REQ-025 SHALL, on resp_valid && resp_ready, go to IDLE; req_ready = 1 in the next cycle. Minimum request-to-request spacing is LATENCY+1 cycles.
REQ-026 SHALL ignore resp_ready outside RESP and ignore req_valid outside IDLE.
REQ-027 SHALL drive resp_valid = 0 and resp_rdata = 0 in IDLE and WAIT.

Reset
REQ-028 SHALL, while rst = 0, force: state to IDLE; counter to 0; req_ready = 0; resp_valid = 0; resp_rdata = 0; resp_err = 0; latched request fields to 0.
REQ-029 SHALL drive req_ready = 1 on the first cycle after rst returns to 1.
REQ-030 SHALL abort any in-flight request when reset is asserted mid-operation: no response is issued, and a write not yet performed is lost.
REQ-031 SHALL NOT reset the mem contents.

Configuration
REQ-032 SHALL use the macro MEM_RESP_RANGE_CHECK_EN to control range checking.
REQ-033 SHALL, with MEM_RESP_RANGE_CHECK_EN defined, treat a request with any req_addr bit at or above 4+log2(NUM_LINES) set as out-of-range, and in that case: resp_err = 1 in RESP, resp_rdata = 0, no mem write, same latency as a normal request.
REQ-034 SHALL, without MEM_RESP_RANGE_CHECK_EN, ignore the upper address bits (addresses wrap modulo NUM_LINES lines) and tie resp_err to 0.

Verification
REQ-035 SHALL be verified for reset: hold rst = 0 for 2 cycles, then release -> req_ready = 1 and resp_valid = 0 on the next cycle; mem is preloaded by backdoor.
REQ-036 SHALL be verified for read latency: backdoor mem[0] = {00100093,00200113,002081b3,00200113}, read addr 0x0 with LATENCY = 4, resp_ready = 1 -> resp_valid exactly 4 cycles after acceptance with resp_rdata equal to mem[0].
REQ-037 SHALL be verified for write then read: write addr 0x10 with {00300293,00300313,00310333,00300313}, then read 0x14 -> the read returns the same line and the write response has rdata = 0.
REQ-038 SHALL be verified for backpressure: a read with resp_ready = 0 for 5 cycles -> resp_valid, resp_rdata and resp_err stay stable and req_ready = 0; resp_ready = 1 -> IDLE on the next cycle.
REQ-039 SHALL be verified for mid-operation reset: assert rst = 0 two cycles after a write to 0x20 is accepted -> no resp_valid, and mem[2] is unchanged.
REQ-040 SHALL be verified for range behaviour: read 0x1000 with NUM_LINES = 256 -> resp_err = 1 and rdata = 0 with MEM_RESP_RANGE_CHECK_EN defined; mem[0] returned and resp_err = 0 without it.
